// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry,
// the hard-wired zero register index and the busy-vector width helper.
package rf_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 2;
  localparam int REG_ZERO   = 0;

  // One busy bit per architectural register.
  function automatic int busy_width(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding writeback and
// raises stall on RAW/WAW hazards. WRITE_BYPASS_EN hides the bit being
// written back this cycle, because its value is forwarded to the readers.
module rf_scoreboard import rf_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             rr1,
  input  logic [ADDR_W-1:0]             rr2,
  input  logic                          issue_valid,
  input  logic                          issue_wen,
  input  logic [ADDR_W-1:0]             issue_rd,
  input  logic                          regwrite,
  input  logic [ADDR_W-1:0]             wr,
  output logic                          stall,
  output logic [busy_width(ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]               pending_cnt
);

  localparam int NUM_REGS = busy_width(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [NUM_REGS-1:0] busy_q, busy_d, busy_vis;
  logic [ADDR_W:0]     pending_cnt_q, pending_cnt_d;
  logic                wb_hit, set_hit;

  function automatic logic [ADDR_W:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [ADDR_W:0] n;
    n = '0;
    for (int i = 0; i < NUM_REGS; i++) n = n + (ADDR_W+1)'(v[i]);
    return n;
  endfunction

  always_comb begin
    wb_hit   = regwrite && (wr != ZERO_A);
    busy_vis = busy_q;
`ifdef WRITE_BYPASS_EN
    if (wb_hit) busy_vis[wr] = 1'b0;
`endif
    stall = issue_valid &&
            (busy_vis[rr1] || busy_vis[rr2] || (issue_wen && busy_vis[issue_rd]));
    set_hit = issue_valid && !stall && issue_wen && (issue_rd != ZERO_A);

    // Clear before set so a new producer on the same register keeps ownership.
    busy_d = busy_q;
    if (wb_hit)  busy_d[wr]       = 1'b0;
    if (set_hit) busy_d[issue_rd] = 1'b1;
    busy_d[REG_ZERO] = 1'b0;
    pending_cnt_d = popcount(busy_d);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy_q        <= '0;
      pending_cnt_q <= '0;
    end else begin
      busy_q        <= busy_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = pending_cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file (two combinational reads, one synchronous write,
// register 0 reads zero) with an integrated hazard scoreboard.
// Optional write-through forwarding is enabled by defining WRITE_BYPASS_EN.
module reg_file_sb import rf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             rr1,
  input  logic [ADDR_W-1:0]             rr2,
  output logic [DATA_W-1:0]             rd1,
  output logic [DATA_W-1:0]             rd2,
  input  logic                          regwrite,
  input  logic [ADDR_W-1:0]             wr,
  input  logic [DATA_W-1:0]             wd,
  input  logic                          issue_valid,
  input  logic                          issue_wen,
  input  logic [ADDR_W-1:0]             issue_rd,
  output logic                          stall,
  output logic [busy_width(ADDR_W)-1:0] busy,
  output logic [ADDR_W:0]               pending_cnt
);

  localparam int NUM_REGS = busy_width(ADDR_W);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              wb_hit;

  assign wb_hit = regwrite && (wr != ZERO_A);

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = (addr == ZERO_A) ? '0 : regs_q[addr];
`ifdef WRITE_BYPASS_EN
    // Forward only outside reset so reads stay zero while reset is held.
    if (reset_n && wb_hit && (addr == wr)) v = wd;
`endif
    return v;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wb_hit) regs_d[wr] = wd;
    regs_d[REG_ZERO] = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd1 = read_port(rr1);
    rd2 = read_port(rr2);
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .rr1        (rr1),
    .rr2        (rr2),
    .issue_valid(issue_valid),
    .issue_wen  (issue_wen),
    .issue_rd   (issue_rd),
    .regwrite   (regwrite),
    .wr         (wr),
    .stall      (stall),
    .busy       (busy),
    .pending_cnt(pending_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed hazard scenarios, a randomized run against
// an array-based reference model, and a 32x8 parametrised instance.
module tb_reg_file_sb;

`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  rr1, rr2, wr, issue_rd;
  logic [15:0] rd1, rd2, wd;
  logic        regwrite, issue_valid, issue_wen, stall;
  logic [3:0]  busy;
  logic [2:0]  pending_cnt;

  logic [2:0]  b_rr1, b_rr2, b_wr, b_issue_rd;
  logic [31:0] b_rd1, b_rd2, b_wd;
  logic        b_regwrite, b_issue_valid, b_issue_wen, b_stall;
  logic [7:0]  b_busy;
  logic [3:0]  b_pending_cnt;

  int checks = 0;
  int passes = 0;

  logic [15:0] mregs [4];
  bit          mbusy [4];

  always #5 clock = ~clock;

  reg_file_sb dut (
    .clock(clock), .reset_n(reset_n), .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
    .regwrite(regwrite), .wr(wr), .wd(wd), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .stall(stall), .busy(busy),
    .pending_cnt(pending_cnt)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(3)) dut_big (
    .clock(clock), .reset_n(reset_n), .rr1(b_rr1), .rr2(b_rr2), .rd1(b_rd1), .rd2(b_rd2),
    .regwrite(b_regwrite), .wr(b_wr), .wd(b_wd), .issue_valid(b_issue_valid),
    .issue_wen(b_issue_wen), .issue_rd(b_issue_rd), .stall(b_stall), .busy(b_busy),
    .pending_cnt(b_pending_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: registers and pending-write flags as plain arrays.
  function automatic bit forwarded(input logic [1:0] a);
    return BYP && regwrite && (wr != 0) && (a == wr);
  endfunction

  function automatic bit pending(input logic [1:0] a);
    return (a != 0) && mbusy[a] && !forwarded(a);
  endfunction

  function automatic logic [15:0] exp_rd(input logic [1:0] a);
    if (a == 0) return 16'h0;
    if (forwarded(a) && reset_n) return wd;
    return mregs[a];
  endfunction

  function automatic bit exp_stall();
    return issue_valid && (pending(rr1) || pending(rr2) || (issue_wen && pending(issue_rd)));
  endfunction

  function automatic logic [3:0] exp_busy();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = mbusy[i];
    return v;
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < 4; i++) n += int'(mbusy[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mregs[i] = 16'h0;
      mbusy[i] = 1'b0;
    end
  endtask

  // Check every output just before the edge, then advance the model across it.
  task automatic cyc();
    bit          acc;
    logic        w_en, i_wen;
    logic [1:0]  w_a, i_rd;
    logic [15:0] w_d;
    #1;
    chk("rd1", rd1, exp_rd(rr1));
    chk("rd2", rd2, exp_rd(rr2));
    chk("stall", stall, exp_stall());
    chk("busy", busy, exp_busy());
    chk("pending_cnt", pending_cnt, exp_cnt());
    acc = issue_valid && !exp_stall();
    w_en = regwrite; w_a = wr; w_d = wd; i_wen = issue_wen; i_rd = issue_rd;
    @(posedge clock);
    if (w_en && w_a != 0) begin
      mregs[w_a] = w_d;
      mbusy[w_a] = 1'b0;
    end
    if (acc && i_wen && i_rd != 0) mbusy[i_rd] = 1'b1;
    #1;
  endtask

  task automatic idle();
    regwrite = 0; wr = 0; wd = 0; issue_valid = 0; issue_wen = 0; issue_rd = 0;
    rr1 = 0; rr2 = 0;
  endtask

  task automatic issue(input logic [1:0] dst, input logic [1:0] a1, input logic [1:0] a2);
    issue_valid = 1; issue_wen = 1; issue_rd = dst; rr1 = a1; rr2 = a2;
  endtask

  initial begin
    idle();
    b_rr1 = 0; b_rr2 = 0; b_wr = 0; b_wd = 0; b_regwrite = 0;
    b_issue_valid = 0; b_issue_wen = 0; b_issue_rd = 0;
    model_reset();
    reset_n = 0;
    repeat (2) @(posedge clock);
    #1;
    issue_valid = 1; rr1 = 1; rr2 = 2;
    #1;
    chk("reset_rd1", rd1, 16'h0);
    chk("reset_stall", stall, 1'b0);
    chk("reset_busy", busy, 4'b0000);
    chk("reset_cnt", pending_cnt, 3'd0);
    idle();
    reset_n = 1;
    @(posedge clock); #1;

    // Writes to register 0 are ignored.
    regwrite = 1; wr = 0; wd = 16'hFFFF;
    cyc();
    idle();
    #1;
    chk("zero_rd1", rd1, 16'h0);
    chk("zero_busy0", busy[0], 1'b0);
    chk("zero_cnt", pending_cnt, 3'd0);

    // RAW hazard on register 2.
    issue(2, 0, 0);
    cyc();
    chk("raw_busy", busy, 4'b0100);
    chk("raw_cnt", pending_cnt, 3'd1);
    idle(); issue_valid = 1; rr1 = 2;
    #1;
    chk("raw_stall", stall, 1'b1);
    cyc();
    regwrite = 1; wr = 2; wd = 16'h0042;
    #1;
    chk("raw_wb_stall", stall, BYP ? 1'b0 : 1'b1);
    chk("raw_wb_rd1", rd1, BYP ? 16'h0042 : 16'h0000);
    cyc();
    regwrite = 0; wr = 0; wd = 0;
    #1;
    chk("raw_after_stall", stall, 1'b0);
    chk("raw_after_rd1", rd1, 16'h0042);
    cyc();

    // WAW hazard on register 3.
    issue(3, 0, 0);
    cyc();
    #1;
    chk("waw_stall", stall, 1'b1);
    cyc();
    chk("waw_busy", busy, 4'b1000);
    chk("waw_cnt", pending_cnt, 3'd1);

    // Writeback and new producer on register 1 in the same cycle.
    issue(1, 0, 0);
    cyc();
    regwrite = 1; wr = 1; wd = 16'h0007;
    cyc();
    idle(); rr1 = 1;
    cyc();
    chk("setclr_rd1", rd1, 16'h0007);
    chk("setclr_busy", busy, BYP ? 4'b1010 : 4'b1000);
    chk("setclr_cnt", pending_cnt, BYP ? 3'd2 : 3'd1);

    // Asynchronous reset in the middle of a cycle with live state.
    idle(); regwrite = 1; wr = 1; wd = 16'h1234;
    cyc();
    idle(); issue(2, 0, 0);
    cyc();
    idle(); rr1 = 1;
    cyc();
    chk("pre_reset_rd1", rd1, 16'h1234);
    issue_valid = 1; rr2 = 3;
    #2;
    reset_n = 0;
    #1;
    model_reset();
    chk("midreset_rd1", rd1, 16'h0);
    chk("midreset_busy", busy, 4'b0000);
    chk("midreset_cnt", pending_cnt, 3'd0);
    chk("midreset_stall", stall, 1'b0);
    @(posedge clock); #1;
    idle();
    reset_n = 1;
    @(posedge clock); #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      regwrite    = ($urandom_range(0, 2) == 0);
      wr          = 2'($urandom);
      wd          = 16'($urandom);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_wen   = $urandom_range(0, 1) == 1;
      issue_rd    = 2'($urandom);
      rr1         = 2'($urandom);
      rr2         = 2'($urandom);
      cyc();
    end
    idle();

    // 32-bit, 8-register instance: fill the scoreboard.
    b_regwrite = 1; b_wr = 7; b_wd = 32'hDEADBEEF;
    @(posedge clock); #1;
    b_regwrite = 0;
    for (int i = 1; i < 8; i++) begin
      b_issue_valid = 1; b_issue_wen = 1; b_issue_rd = 3'(i);
      #1;
      chk("big_issue_stall", b_stall, 1'b0);
      @(posedge clock); #1;
    end
    b_issue_valid = 0; b_rr2 = 7; b_rr1 = 0;
    #1;
    chk("big_cnt", b_pending_cnt, 4'd7);
    chk("big_busy", b_busy, 8'hFE);
    chk("big_rd2", b_rd2, 32'hDEADBEEF);
    chk("big_rd1_zero", b_rd1, 32'h0);
    b_issue_valid = 1; b_issue_wen = 1; b_issue_rd = 1;
    #1;
    chk("big_waw_stall", b_stall, 1'b1);
    @(posedge clock); #1;
    chk("big_cnt_hold", b_pending_cnt, 4'd7);
    b_issue_valid = 0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
